mult_seq_8bit: RTL and testbench

Sequential 8×8 unsigned shift-and-add multiplier for the calculator datapath. It reuses one `ripple_adder_8bit` instance as its only adder and runs it once per multiplier bit over eight cycles. It accepts operands on a start handshake and returns a registered 16-bit product with a one-cycle `done` pulse. The calculator control FSM uses it as the multiply engine alongside the existing add path.

---
 rtl/calc_pkg.sv | 14 +
 rtl/mult_seq_8bit_if.sv | 23 ++
 rtl/ripple_adder_8bit.sv | 21 ++
 rtl/mult_seq_8bit.sv | 90 +++++++++
 tb/tb_mult_seq_8bit.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/calc_pkg.sv
// Shared calculator datapath definitions: multiplier width, iteration count
// and the multiply-engine state encoding.
package calc_pkg;

    localparam int MUL_W    = 8;
    localparam int MUL_ITER = 8;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t DONE = 2'd2;

endpackage

// File: rtl/mult_seq_8bit_if.sv
// Start/result handshake between the calculator control FSM (master) and the
// sequential multiply engine (slave).
interface mult_seq_8bit_if;
    import calc_pkg::*;

    logic                 start;
    logic [MUL_W-1:0]     a;
    logic [MUL_W-1:0]     b;
    logic                 busy;
    logic                 done;
    logic [2*MUL_W-1:0]   product;

    modport master (
        output start, a, b,
        input  busy, done, product
    );

    modport slave (
        input  start, a, b,
        output busy, done, product
    );

endinterface

// File: rtl/ripple_adder_8bit.sv
// 8-bit ripple-carry adder built from a chain of full-adder cells.
module ripple_adder_8bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    logic [8:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < 8; i++) begin : g_fa
        assign sum[i]     = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (a[i] & carry[i]) | (b[i] & carry[i]);
    end

    assign cout = carry[8];

endmodule

// File: rtl/mult_seq_8bit.sv
// Sequential 8x8 unsigned shift-and-add multiplier: one shared ripple adder,
// one multiplier bit per cycle, registered 16-bit product with a done pulse.
module mult_seq_8bit
    import calc_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    mult_seq_8bit_if.slave    bus
);

    state_t                state;
    logic [MUL_W-1:0]      m;
    logic [MUL_W-1:0]      acc;
    logic [MUL_W-1:0]      q;
    logic [2:0]            cnt;
    logic [MUL_W-1:0]      sum;
    logic                  carry;
    logic [2*MUL_W-1:0]    next_aq;
    logic [2*MUL_W-1:0]    product;
    logic                  busy;
    logic                  done;

    ripple_adder_8bit u_adder (
        .a    (acc),
        .b    (m),
        .cin  (1'b0),
        .sum  (sum),
        .cout (carry)
    );

    // Carry lands in the top bit of the shifted accumulator, so no result bit is lost.
    always_comb begin
        next_aq = {1'b0, acc, q[MUL_W-1:1]};
        if (q[0]) begin
            next_aq = {carry, sum, q[MUL_W-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            m       <= '0;
            acc     <= '0;
            q       <= '0;
            cnt     <= '0;
            product <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (bus.start) begin
                        m     <= bus.a;
                        q     <= bus.b;
                        acc   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc <= next_aq[2*MUL_W-1:MUL_W];
                    q   <= next_aq[MUL_W-1:0];
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'(MUL_ITER - 1)) begin
                        product <= next_aq;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = busy;
    assign bus.done    = done;
    assign bus.product = product;

endmodule

// File: tb/tb_mult_seq_8bit.sv
// Directed and randomized bench for mult_seq_8bit against a plain a*b model.
module tb_mult_seq_8bit;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    mult_seq_8bit_if bus ();

    mult_seq_8bit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model(input logic [7:0] x, input logic [7:0] y);
        return 16'(int'(x) * int'(y));
    endfunction

    // Issue one multiply and verify busy length, done pulse and product.
    task automatic do_mul(input logic [7:0] x, input logic [7:0] y, input string tag);
        int n;
        int busy_gaps;
        bus.start = 1'b1;
        bus.a     = x;
        bus.b     = y;
        tick();
        bus.start = 1'b0;
        bus.a     = ~x;
        bus.b     = ~y;
        n         = 0;
        busy_gaps = 0;
        while (!bus.done && n < 20) begin
            if (!bus.busy) busy_gaps++;
            n++;
            tick();
        end
        chk({tag, "_busy_cycles"}, n, 8);
        chk({tag, "_busy_gaps"}, busy_gaps, 0);
        chk({tag, "_busy_at_done"}, {31'd0, bus.busy}, 0);
        chk({tag, "_product"}, {16'd0, bus.product}, {16'd0, model(x, y)});
        tick();
        chk({tag, "_done_pulse"}, {31'd0, bus.done}, 0);
    endtask

    initial begin
        int n;
        int rises;
        int dones;
        int last_done;
        int interval_bad;
        logic [7:0] ra;
        logic [7:0] rb;

        bus.start = 1'b0;
        bus.a     = 8'h00;
        bus.b     = 8'h00;

        // Reset and idle behaviour
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_busy", {31'd0, bus.busy}, 0);
        chk("rst_done", {31'd0, bus.done}, 0);
        chk("rst_product", {16'd0, bus.product}, 0);
        rises = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.busy || bus.done) rises++;
        end
        chk("idle_quiet", rises, 0);

        // Directed operand patterns
        do_mul(8'h0C, 8'h0A, "m_0c_0a");
        rises = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.product !== 16'h0078) rises++;
        end
        chk("hold_product", rises, 0);
        do_mul(8'hFF, 8'hFF, "m_ff_ff");
        do_mul(8'h00, 8'hFF, "m_00_ff");
        do_mul(8'h80, 8'h02, "m_80_02");

        // Start during RUN is ignored
        bus.start = 1'b1;
        bus.a     = 8'h12;
        bus.b     = 8'h34;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        bus.start = 1'b1;
        bus.a     = 8'hFF;
        bus.b     = 8'hFF;
        tick();
        bus.start = 1'b0;
        dones = 0;
        n     = 0;
        while (n < 30) begin
            if (bus.done) begin
                dones++;
                chk("ignore_product", {16'd0, bus.product}, 32'h03A8);
            end
            n++;
            tick();
        end
        chk("ignore_done_count", dones, 1);

        // Reset mid-run discards the partial result
        bus.start = 1'b1;
        bus.a     = 8'hFF;
        bus.b     = 8'hFF;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_busy", {31'd0, bus.busy}, 0);
        chk("midrst_done", {31'd0, bus.done}, 0);
        chk("midrst_product", {16'd0, bus.product}, 0);
        do_mul(8'h03, 8'h05, "m_03_05");

        // Reset wins over a simultaneous start
        rst       = 1'b1;
        bus.start = 1'b1;
        bus.a     = 8'h11;
        bus.b     = 8'h22;
        tick();
        rst       = 1'b0;
        bus.start = 1'b0;
        chk("rst_start_busy0", {31'd0, bus.busy}, 0);
        tick();
        chk("rst_start_busy1", {31'd0, bus.busy}, 0);

        // Back-to-back with start held high
        bus.start    = 1'b1;
        bus.a        = 8'h11;
        bus.b        = 8'h11;
        dones        = 0;
        last_done    = -1;
        interval_bad = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (bus.busy && bus.done) interval_bad++;
            if (bus.done) begin
                chk("b2b_product", {16'd0, bus.product}, 32'h0121);
                if (last_done >= 0 && (i - last_done < 9 || i - last_done > 10)) interval_bad++;
                last_done = i;
                dones++;
            end
        end
        bus.start = 1'b0;
        chk("b2b_interval", interval_bad, 0);
        chk("b2b_min_dones", {31'd0, (dones >= 5)}, 1);
        for (int i = 0; i < 12; i++) tick();

        // Randomized scoreboard
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom_range(255));
            rb = 8'($urandom_range(255));
            do_mul(ra, rb, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
